// File: rtl/disp_colour_out.sv
// Display output stage: converts system colour depth to board colour depth,
// applies frame-synchronous output modes and delays sync/enable so that every
// output appears exactly PIPE cycles after the corresponding input sample.
module disp_colour_out #(
    parameter int BPC_IN    = 5,
    parameter int BPC_OUT   = 8,
    parameter int CORDW     = 16,
    parameter int PIPE      = 2,
    parameter int BAR_W     = 80,
    parameter int SYNC_IDLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_hsync,
    input  logic               disp_vsync,
    input  logic               disp_de,
    input  logic               disp_frame,
    input  logic [BPC_IN-1:0]  disp_r,
    input  logic [BPC_IN-1:0]  disp_g,
    input  logic [BPC_IN-1:0]  disp_b,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_we,
    output logic [BPC_OUT-1:0] board_r,
    output logic [BPC_OUT-1:0] board_g,
    output logic [BPC_OUT-1:0] board_b,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_de,
    output logic [1:0]         mode_active
);

    localparam logic SYNC_RST = (SYNC_IDLE != 0);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_BLACK  = 2'd1,
        MODE_BARS   = 2'd2,
        MODE_TRUNC  = 2'd3
    } mode_t;

    mode_t mode_q;
    mode_t pend_q;

    // Mode register: requests are staged and only take effect at frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_NORMAL;
            pend_q <= MODE_NORMAL;
        end else begin
            if (cfg_we) begin
                pend_q <= mode_t'(cfg_mode);
            end
            if (disp_frame) begin
                mode_q <= cfg_we ? mode_t'(cfg_mode) : pend_q;
            end
        end
    end

    assign mode_active = mode_q;

    // Colour bar position: sub-counter within a bar and saturating bar index
    logic [CORDW-1:0] bar_cnt;
    logic [2:0]       bar_idx;

    always_ff @(posedge clk) begin
        if (rst || !disp_de) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (bar_cnt == CORDW'(BAR_W - 1)) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) begin
                bar_idx <= bar_idx + 3'd1;
            end
        end else begin
            bar_cnt <= bar_cnt + CORDW'(1);
        end
    end

    logic [BPC_OUT-1:0] conv_r;
    logic [BPC_OUT-1:0] conv_g;
    logic [BPC_OUT-1:0] conv_b;

    if (BPC_OUT >= BPC_IN) begin : g_widen
        localparam int REP = (BPC_OUT + BPC_IN - 1) / BPC_IN;

        // Repeat the input MSB-first and keep the top BPC_OUT bits
        function automatic logic [BPC_OUT-1:0] widen(input logic [BPC_IN-1:0] c);
            logic [REP*BPC_IN-1:0] rep;
            rep = {REP{c}};
            return BPC_OUT'(rep >> (REP * BPC_IN - BPC_OUT));
        endfunction

        // Widening is identical in NORMAL and TRUNC
        always_comb begin
            conv_r = widen(disp_r);
            conv_g = widen(disp_g);
            conv_b = widen(disp_b);
        end
    end else begin : g_narrow
        localparam int D  = BPC_IN - BPC_OUT;
        localparam int SH = (D >= 2) ? D - 2 : 0;

        logic       x_par;
        logic       y_par;
        logic       de_d;
        logic [1:0] bayer;
        logic [BPC_IN:0] thr;

        // Add threshold, saturate on carry, drop the D low bits
        function automatic logic [BPC_OUT-1:0] narrow(input logic [BPC_IN-1:0] c,
                                                      input logic [BPC_IN:0]   t);
            logic [BPC_IN:0] s;
            s = {1'b0, c} + t;
            return s[BPC_IN] ? '1 : BPC_OUT'(s >> D);
        endfunction

        // Pixel/line parity for the 2x2 ordered dither
        always_ff @(posedge clk) begin
            if (rst) begin
                x_par <= 1'b0;
                y_par <= 1'b0;
                de_d  <= 1'b0;
            end else begin
                x_par <= disp_de ? ~x_par : 1'b0;
                de_d  <= disp_de;
                if (disp_frame) begin
                    y_par <= 1'b0;
                end else if (de_d && !disp_de) begin
                    y_par <= ~y_par;
                end
            end
        end

        // Bayer threshold scaled to the number of dropped bits; zero in TRUNC
        always_comb begin
            case ({y_par, x_par})
                2'b00:   bayer = 2'd0;
                2'b01:   bayer = 2'd2;
                2'b10:   bayer = 2'd3;
                default: bayer = 2'd1;
            endcase
            thr = '0;
            if (mode_q != MODE_TRUNC) begin
                if (D >= 2) begin
                    thr = (BPC_IN+1)'(bayer) << SH;
                end else begin
                    thr = (BPC_IN+1)'(bayer >> 1);
                end
            end
        end

        // Dithered or truncated narrowing of each channel
        always_comb begin
            conv_r = narrow(disp_r, thr);
            conv_g = narrow(disp_g, thr);
            conv_b = narrow(disp_b, thr);
        end
    end

    logic [BPC_OUT-1:0] col_r;
    logic [BPC_OUT-1:0] col_g;
    logic [BPC_OUT-1:0] col_b;

    // Output colour per mode; blanking forces black in every mode
    always_comb begin
        col_r = '0;
        col_g = '0;
        col_b = '0;
        if (disp_de) begin
            case (mode_q)
                MODE_NORMAL, MODE_TRUNC: begin
                    col_r = conv_r;
                    col_g = conv_g;
                    col_b = conv_b;
                end
                MODE_BARS: begin
                    col_r = {BPC_OUT{bar_idx[2]}};
                    col_g = {BPC_OUT{bar_idx[1]}};
                    col_b = {BPC_OUT{bar_idx[0]}};
                end
                default: begin
                    col_r = '0;
                    col_g = '0;
                    col_b = '0;
                end
            endcase
        end
    end

    logic [BPC_OUT-1:0] pipe_r  [PIPE];
    logic [BPC_OUT-1:0] pipe_g  [PIPE];
    logic [BPC_OUT-1:0] pipe_b  [PIPE];
    logic               pipe_hs [PIPE];
    logic               pipe_vs [PIPE];
    logic               pipe_de [PIPE];

    // Delay line: stage 0 captures the input sample, last stage drives the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < unsigned'(PIPE); i++) begin
                pipe_r[i]  <= '0;
                pipe_g[i]  <= '0;
                pipe_b[i]  <= '0;
                pipe_hs[i] <= SYNC_RST;
                pipe_vs[i] <= SYNC_RST;
                pipe_de[i] <= 1'b0;
            end
        end else begin
            pipe_r[0]  <= col_r;
            pipe_g[0]  <= col_g;
            pipe_b[0]  <= col_b;
            pipe_hs[0] <= disp_hsync;
            pipe_vs[0] <= disp_vsync;
            pipe_de[0] <= disp_de;
            for (int unsigned i = 1; i < unsigned'(PIPE); i++) begin
                pipe_r[i]  <= pipe_r[i-1];
                pipe_g[i]  <= pipe_g[i-1];
                pipe_b[i]  <= pipe_b[i-1];
                pipe_hs[i] <= pipe_hs[i-1];
                pipe_vs[i] <= pipe_vs[i-1];
                pipe_de[i] <= pipe_de[i-1];
            end
        end
    end

    assign board_r   = pipe_r[PIPE-1];
    assign board_g   = pipe_g[PIPE-1];
    assign board_b   = pipe_b[PIPE-1];
    assign out_hsync = pipe_hs[PIPE-1];
    assign out_vsync = pipe_vs[PIPE-1];
    assign out_de    = pipe_de[PIPE-1];

endmodule
